// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the debug dump sequencer and the UART command decoder.
// The S_CSUM state exists only when DBG_CHECKSUM_EN is defined.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    CMD_RUN  = 2'b00,
    CMD_STEP = 2'b01,
    CMD_DUMP = 2'b10,
    CMD_RSVD = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_ADDR,
    S_LATCH,
    S_SEND,
`ifdef DBG_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_PC,
    PH_REG,
    PH_MEM
  } phase_e;

  // Number of UART bytes needed to carry one debug word.
  function automatic int dbg_bytes(input int data_sz, input int uart_sz);
    return (data_sz + uart_sz - 1) / uart_sz;
  endfunction

endpackage

// File: rtl/dbg_word_serializer.sv
// Loads one debug word and hands it out LSB-first as UART bytes, zero-padding the top byte.
module dbg_word_serializer
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_SZ = 32,
  parameter int UART_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               load,
  input  logic [DATA_SZ-1:0] i_word,
  input  logic               advance,
  output logic [UART_SZ-1:0] o_byte,
  output logic               o_last
);

  localparam int BYTES = dbg_bytes(DATA_SZ, UART_SZ);
  localparam int SR_W  = BYTES * UART_SZ;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

  logic [SR_W-1:0]  shift_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= SR_W'(i_word);
      cnt_q   <= '0;
    end else if (advance) begin
      shift_q <= shift_q >> UART_SZ;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  assign o_byte = shift_q[UART_SZ-1:0];
  assign o_last = (cnt_q == CNT_LAST);

endmodule

// File: rtl/debug_dump_ctrl.sv
// Run/step/dump sequencer between the UART command path and the pipeline debug port.
// Define DBG_CHECKSUM_EN to append an XOR checksum byte after the dump.
module debug_dump_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_SZ = 32,
  parameter int UART_SZ = 8,
  parameter int W       = 5,
  parameter int NREG    = 32,
  parameter int NMEM    = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  input  logic [1:0]         i_cmd,
  output logic               o_cmd_ready,
  input  logic               i_halt,
  output logic               o_enable,
  output logic [W-1:0]       o_debug_addr,
  input  logic [DATA_SZ-1:0] i_pc,
  input  logic [DATA_SZ-1:0] i_reg_data,
  input  logic [DATA_SZ-1:0] i_mem_data,
  output logic [UART_SZ-1:0] o_tx_data,
  output logic               o_tx_wr,
  input  logic               i_tx_full,
  output logic               o_busy,
  output logic               o_done
);

  // One extra index bit lets NREG or NMEM equal 2^W without wrapping.
  localparam logic [W:0] REG_LAST = (W+1)'(NREG - 1);
  localparam logic [W:0] MEM_LAST = (W+1)'(NMEM - 1);

  state_e             state, state_next;
  phase_e             phase, phase_next;
  logic [W:0]         idx, idx_next;
  logic               ser_load;
  logic               ser_last;
  logic [UART_SZ-1:0] ser_byte;
  logic [DATA_SZ-1:0] word_sel;
  logic               tx_wr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      phase <= PH_PC;
      idx   <= '0;
    end else begin
      state <= state_next;
      phase <= phase_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    phase_next = phase;
    idx_next   = idx;
    o_enable   = 1'b0;
    tx_wr      = 1'b0;
    ser_load   = 1'b0;
    o_done     = 1'b0;
    case (state)
      S_IDLE: begin
        phase_next = PH_PC;
        idx_next   = '0;
        if (i_cmd_valid) begin
          case (cmd_e'(i_cmd))
            CMD_RUN:  state_next = S_RUN;
            CMD_STEP: state_next = S_STEP;
            CMD_DUMP: state_next = S_ADDR;
            default:  state_next = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        o_enable = !i_halt;
        if (i_halt) state_next = S_ADDR;
      end
      S_STEP: begin
        o_enable   = !i_halt;
        state_next = S_ADDR;
      end
      S_ADDR:  state_next = S_LATCH;
      S_LATCH: begin
        ser_load   = 1'b1;
        state_next = S_SEND;
      end
      S_SEND: begin
        tx_wr = !i_tx_full;
        if (tx_wr && ser_last) begin
          state_next = S_ADDR;
          case (phase)
            PH_PC: begin
              phase_next = PH_REG;
              idx_next   = '0;
            end
            PH_REG: begin
              if (idx == REG_LAST) begin
                phase_next = PH_MEM;
                idx_next   = '0;
              end else begin
                idx_next = idx + (W+1)'(1);
              end
            end
            default: begin
              if (idx == MEM_LAST) begin
`ifdef DBG_CHECKSUM_EN
                state_next = S_CSUM;
`else
                state_next = S_DONE;
`endif
              end else begin
                idx_next = idx + (W+1)'(1);
              end
            end
          endcase
        end
      end
`ifdef DBG_CHECKSUM_EN
      S_CSUM: begin
        tx_wr = !i_tx_full;
        if (tx_wr) state_next = S_DONE;
      end
`endif
      S_DONE: begin
        o_done     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (phase)
      PH_PC:   word_sel = i_pc;
      PH_REG:  word_sel = i_reg_data;
      default: word_sel = i_mem_data;
    endcase
  end

  dbg_word_serializer #(
    .DATA_SZ(DATA_SZ),
    .UART_SZ(UART_SZ)
  ) u_ser (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .load    (ser_load),
    .i_word  (word_sel),
    .advance (tx_wr && (state == S_SEND)),
    .o_byte  (ser_byte),
    .o_last  (ser_last)
  );

`ifdef DBG_CHECKSUM_EN
  logic [UART_SZ-1:0] csum;

  // Running XOR of every byte actually accepted by the TX FIFO in this dump.
  always_ff @(posedge i_clk) begin
    if (i_reset || state == S_IDLE) begin
      csum <= '0;
    end else if (tx_wr && state == S_SEND) begin
      csum <= csum ^ ser_byte;
    end
  end

  assign o_tx_data = (state == S_CSUM) ? csum : ser_byte;
`else
  assign o_tx_data = ser_byte;
`endif

  assign o_tx_wr      = tx_wr;
  assign o_debug_addr = (phase == PH_PC) ? '0 : idx[W-1:0];
  assign o_cmd_ready  = (state == S_IDLE);
  assign o_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Self-checking bench for debug_dump_ctrl: a 32-bit instance driven from a vector table plus
// hand sequences, and a 20-bit instance for the padding case; aware of DBG_CHECKSUM_EN.
module tb_debug_dump_ctrl;

  localparam int BYTES    = 4;
  localparam int NREG     = 4;
  localparam int NMEM     = 2;
`ifdef DBG_CHECKSUM_EN
  localparam int CSUM_N   = 1;
`else
  localparam int CSUM_N   = 0;
`endif
  localparam int NBYTES   = (1 + NREG + NMEM) * BYTES + CSUM_N;
  localparam int B_NBYTES = (1 + 2 + 1) * 3 + CSUM_N;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic        cmd_ready;
  logic        halt = 1'b0;
  logic        enable;
  logic [1:0]  debug_addr;
  logic [31:0] pc = '0;
  logic [31:0] reg_data = '0;
  logic [31:0] mem_data = '0;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_full = 1'b0;
  logic        busy;
  logic        done;

  logic        b_cmd_valid = 1'b0;
  logic        b_cmd_ready;
  logic        b_enable;
  logic [0:0]  b_debug_addr;
  logic [19:0] b_pc = '0;
  logic [19:0] b_reg_data = '0;
  logic [19:0] b_mem_data = '0;
  logic [7:0]  b_tx_data;
  logic        b_tx_wr;
  logic        b_busy;
  logic        b_done;

  logic [31:0] regs [4];
  logic [31:0] mems [4];
  logic [19:0] b_regs [2];
  logic [19:0] b_mems [2];

  logic [7:0] sb [$];
  logic [7:0] b_sb [$];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [1:0] cmd;
    int         halt_at;
    int         stall_at;
    int         stall_len;
    bit         poke_busy;
    int         exp_enable;
    int         exp_first_wr;
    int         exp_done;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  debug_dump_ctrl #(.DATA_SZ(32), .UART_SZ(8), .W(2), .NREG(NREG), .NMEM(NMEM)) dut (
    .i_clk(clk), .i_reset(reset), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(cmd_ready), .i_halt(halt), .o_enable(enable), .o_debug_addr(debug_addr),
    .i_pc(pc), .i_reg_data(reg_data), .i_mem_data(mem_data), .o_tx_data(tx_data),
    .o_tx_wr(tx_wr), .i_tx_full(tx_full), .o_busy(busy), .o_done(done)
  );

  debug_dump_ctrl #(.DATA_SZ(20), .UART_SZ(8), .W(1), .NREG(2), .NMEM(1)) dut20 (
    .i_clk(clk), .i_reset(reset), .i_cmd_valid(b_cmd_valid), .i_cmd(2'b10),
    .o_cmd_ready(b_cmd_ready), .i_halt(1'b0), .o_enable(b_enable), .o_debug_addr(b_debug_addr),
    .i_pc(b_pc), .i_reg_data(b_reg_data), .i_mem_data(b_mem_data), .o_tx_data(b_tx_data),
    .o_tx_wr(b_tx_wr), .i_tx_full(1'b0), .o_busy(b_busy), .o_done(b_done)
  );

  // Synchronous-read register file and memory models: data one cycle after the address.
  always @(posedge clk) begin
    reg_data   <= regs[debug_addr];
    mem_data   <= mems[debug_addr];
    b_reg_data <= b_regs[b_debug_addr];
    b_mem_data <= b_mems[b_debug_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Fresh random debug contents, and the byte stream a dump of them must produce.
  task automatic loadModel();
    logic [31:0] words [7];
    logic [7:0]  x;
    pc = $urandom();
    for (int i = 0; i < 4; i++) begin
      regs[i] = $urandom();
      mems[i] = $urandom();
    end
    words[0] = pc;
    for (int i = 0; i < NREG; i++) words[1 + i] = regs[i];
    for (int i = 0; i < NMEM; i++) words[1 + NREG + i] = mems[i];
    x = '0;
    sb.delete();
    for (int w = 0; w < 7; w++) begin
      for (int b = 0; b < BYTES; b++) begin
        sb.push_back(8'((words[w] >> (8 * b)) & 32'hff));
        x = x ^ 8'((words[w] >> (8 * b)) & 32'hff);
      end
    end
    if (CSUM_N != 0) sb.push_back(x);
  endtask

  task automatic applyStimulus(input vec_t v);
    int  en_cnt, first_wr, done_at, nwr;
    bit  ready_bad;
    loadModel();
    @(posedge clk); #1;
    cmd = v.cmd;
    cmd_valid = 1'b1;
    halt = (v.halt_at <= 0);
    @(negedge clk);
    checkOutput({v.name, ".ready_before"}, 32'(cmd_ready), 32'd1);
    en_cnt = 0; first_wr = -1; done_at = -1; nwr = 0; ready_bad = 1'b0;
    for (int n = 0; n < 200 && done_at < 0; n++) begin
      @(posedge clk); #1;
      cmd_valid = v.poke_busy && (n >= 5) && (n < 8);
      cmd = 2'b00;
      halt = (n >= v.halt_at);
      tx_full = (n >= v.stall_at) && (n < v.stall_at + v.stall_len);
      @(negedge clk);
      if (enable) en_cnt++;
      if (cmd_ready || !busy) ready_bad = 1'b1;
      if (tx_full) begin
        checkOutput({v.name, ".stall_wr"}, 32'(tx_wr), 32'd0);
        if (sb.size() > 0) checkOutput({v.name, ".stall_hold"}, 32'(tx_data), 32'(sb[0]));
      end
      if (tx_wr) begin
        nwr++;
        if (first_wr < 0) first_wr = n;
        if (sb.size() == 0) checkOutput({v.name, ".extra_byte"}, 32'(tx_data), 32'hffff_ffff);
        else checkOutput({v.name, ".byte"}, 32'(tx_data), 32'(sb.pop_front()));
      end
      if (done) done_at = n;
    end
    tx_full = 1'b0;
    checkOutput({v.name, ".enable_cycles"}, en_cnt, v.exp_enable);
    checkOutput({v.name, ".first_wr"}, first_wr, v.exp_first_wr);
    checkOutput({v.name, ".done_cycle"}, done_at, v.exp_done);
    checkOutput({v.name, ".byte_count"}, nwr, NBYTES);
    checkOutput({v.name, ".sb_left"}, sb.size(), 0);
    checkOutput({v.name, ".busy_flags"}, 32'(ready_bad), 32'd0);
    @(posedge clk); #1;
    halt = 1'b0;
    @(negedge clk);
    checkOutput({v.name, ".ready_after"}, 32'(cmd_ready), 32'd1);
    checkOutput({v.name, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int nwr, done_at;
    bit bad;
    logic [7:0] bx;

    vecs[0] = '{"dump",        2'b10, 1000, 0, 0, 1'b0, 0,  2,  42 + CSUM_N};
    vecs[1] = '{"run_halt10",  2'b00, 10,   0, 0, 1'b0, 10, 13, 53 + CSUM_N};
    vecs[2] = '{"run_halted",  2'b00, 0,    0, 0, 1'b0, 0,  3,  43 + CSUM_N};
    vecs[3] = '{"step",        2'b01, 1000, 0, 0, 1'b0, 1,  3,  43 + CSUM_N};
    vecs[4] = '{"step_halted", 2'b01, 0,    0, 0, 1'b0, 0,  3,  43 + CSUM_N};
    vecs[5] = '{"dump_stall",  2'b10, 1000, 4, 5, 1'b0, 0,  2,  47 + CSUM_N};
    vecs[6] = '{"dump_poke",   2'b10, 1000, 0, 0, 1'b1, 0,  2,  42 + CSUM_N};

    for (int i = 0; i < 4; i++) begin
      regs[i] = '0;
      mems[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      b_regs[i] = '0;
      b_mems[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset.ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.enable", 32'(enable), 32'd0);
    checkOutput("reset.tx_wr", 32'(tx_wr), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.addr", 32'(debug_addr), 32'd0);
    checkOutput("reset.tx_data", 32'(tx_data), 32'd0);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Reserved command is swallowed: nothing starts and no done pulse.
    @(posedge clk); #1;
    cmd = 2'b11;
    cmd_valid = 1'b1;
    @(negedge clk);
    bad = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      if (busy || !cmd_ready || done || tx_wr || enable) bad = 1'b1;
    end
    checkOutput("reserved.quiet", 32'(bad), 32'd0);

    // Reset while REG 2 is being sent, then a clean dump from the PC word.
    loadModel();
    @(posedge clk); #1;
    cmd = 2'b10;
    cmd_valid = 1'b1;
    @(negedge clk);
    nwr = 0;
    for (int n = 0; n < 22; n++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      reset = (n == 21);
      @(negedge clk);
      if (tx_wr) begin
        nwr++;
        checkOutput("midreset.byte", 32'(tx_data), 32'(sb.pop_front()));
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset.bytes_before", nwr, 14);
    checkOutput("midreset.busy", 32'(busy), 32'd0);
    checkOutput("midreset.ready", 32'(cmd_ready), 32'd1);
    checkOutput("midreset.enable", 32'(enable), 32'd0);
    checkOutput("midreset.done", 32'(done), 32'd0);
    applyStimulus(vecs[0]);

    // 20-bit words over an 8-bit UART: three bytes per word, top nibble padded with zero.
    b_pc = 20'($urandom());
    for (int i = 0; i < 2; i++) begin
      b_regs[i] = 20'($urandom());
      b_mems[i] = 20'($urandom());
    end
    bx = '0;
    for (int w = 0; w < 4; w++) begin
      logic [23:0] wv;
      wv = (w == 0) ? {4'h0, b_pc} : (w < 3) ? {4'h0, b_regs[w - 1]} : {4'h0, b_mems[0]};
      for (int b = 0; b < 3; b++) begin
        b_sb.push_back(wv[8*b +: 8]);
        bx = bx ^ wv[8*b +: 8];
      end
    end
    if (CSUM_N != 0) b_sb.push_back(bx);
    @(posedge clk); #1;
    b_cmd_valid = 1'b1;
    @(negedge clk);
    checkOutput("w20.ready_before", 32'(b_cmd_ready), 32'd1);
    nwr = 0;
    done_at = -1;
    for (int n = 0; n < 100 && done_at < 0; n++) begin
      @(posedge clk); #1;
      b_cmd_valid = 1'b0;
      @(negedge clk);
      if (b_enable) checkOutput("w20.enable", 32'(b_enable), 32'd0);
      if (b_tx_wr) begin
        nwr++;
        if (b_sb.size() == 0) checkOutput("w20.extra_byte", 32'(b_tx_data), 32'hffff_ffff);
        else checkOutput("w20.byte", 32'(b_tx_data), 32'(b_sb.pop_front()));
      end
      if (b_done) done_at = n;
    end
    checkOutput("w20.byte_count", nwr, B_NBYTES);
    checkOutput("w20.done_cycle", done_at, 20 + CSUM_N);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("w20.busy_after", 32'(b_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
